fcmp_sched: RTL and testbench

//  Shares one single-precision compare datapath (FEQ/FLT/FLE) between two

---
 rtl/fcmp_sched.sv | 164 ++++++++++++++++
 tb/tb_fcmp_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_sched.sv
// Two-requester shared single-precision compare unit (FEQ/FLT/FLE).
// Round-robin grant feeds a 2-stage pipe: operand register, then result register.

module fcmp_core (
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        cmp,
  output logic        nv
);
  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic a_nan, b_nan, a_snan, b_snan, both_zero, eq, lt;

  always_comb begin
    a_nan     = (&a[30:23]) && (|a[22:0]);
    b_nan     = (&b[30:23]) && (|b[22:0]);
    a_snan    = a_nan && !a[22];
    b_snan    = b_nan && !b[22];
    both_zero = ~|{a[30:0], b[30:0]};
    eq        = both_zero || (a == b);
    // sign-magnitude: magnitude order flips for negatives, +/-0 tie handled above
    if (a[31] != b[31])  lt = a[31] && !both_zero;
    else if (a[31])      lt = a[30:0] > b[30:0];
    else                 lt = a[30:0] < b[30:0];

    cmp = 1'b0;
    nv  = 1'b0;
    if (a_nan || b_nan) begin
      if (op == OP_FEQ)                     nv = a_snan || b_snan;
      else if (op == OP_FLT || op == OP_FLE) nv = 1'b1;
    end else begin
      case (op)
        OP_FEQ:  cmp = eq;
        OP_FLT:  cmp = lt;
        OP_FLE:  cmp = lt || eq;
        default: cmp = 1'b0;
      endcase
    end
  end
endmodule

module fcmp_sched #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [31:0]      req0_x1,
  input  logic [31:0]      req0_x2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req1_x1,
  input  logic [31:0]      req1_x2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             resp_nv
);
  localparam int NREQ = 2;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [1:0]       op;
    logic [31:0]      x1;
    logic [31:0]      x2;
  } s1_t;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic             cmp;
    logic             nv;
  } s2_t;

  logic [NREQ-1:0]             vld, rdy, acc;
  logic [NREQ-1:0][1:0]        op_a;
  logic [NREQ-1:0][31:0]       x1_a, x2_a;
  logic [NREQ-1:0][TAG_W-1:0]  tag_a;

  logic [2:1] vld_pipe;
  logic       rr_ptr;
  s1_t        s1, sel;
  s2_t        s2;
  logic       s1_en, s2_en, base_rdy, accept, gidx, cmp, nv;

  assign vld   = {req1_valid, req0_valid};
  assign op_a  = {req1_op, req0_op};
  assign x1_a  = {req1_x1, req0_x1};
  assign x2_a  = {req1_x2, req0_x2};
  assign tag_a = {req1_tag, req0_tag};

  assign s2_en    = !vld_pipe[2] || resp_ready;
  assign s1_en    = !vld_pipe[1] || s2_en;
  assign base_rdy = s1_en && !flush && !rst;

  // Each port's ready looks only at the other port's valid, never its own.
  for (genvar g = 0; g < NREQ; g++) begin : g_rdy
    assign rdy[g] = base_rdy && (!vld[NREQ-1-g] || rr_ptr == 1'(g));
  end

  assign acc        = vld & rdy;
  assign accept     = |acc;
  assign gidx       = acc[1];
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  always_comb begin
    sel     = '0;
    sel.src = gidx;
    sel.tag = tag_a[gidx];
    sel.op  = op_a[gidx];
    sel.x1  = x1_a[gidx];
    sel.x2  = x2_a[gidx];
  end

  fcmp_core u_core (
    .op  (s1.op),
    .a   (s1.x1),
    .b   (s1.x2),
    .cmp (cmp),
    .nv  (nv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      rr_ptr   <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (accept) rr_ptr <= ~gidx;
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        if (s2_en) begin
          vld_pipe[2] <= vld_pipe[1];
          if (vld_pipe[1]) s2 <= '{src: s1.src, tag: s1.tag, cmp: cmp, nv: nv};
        end
        if (s1_en) begin
          vld_pipe[1] <= accept;
          if (accept) s1 <= sel;
        end
      end
    end
  end

  assign resp_valid = vld_pipe[2];
  assign resp_src   = s2.src;
  assign resp_tag   = s2.tag;
  assign resp_data  = {31'b0, s2.cmp};
  assign resp_nv    = s2.nv;
endmodule

// File: tb/tb_fcmp_sched.sv
// Directed + swept checks for fcmp_sched: latency, compare semantics, arbitration,
// backpressure, flush and async reset.

module tb_fcmp_sched;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic [4:0]  req0_tag, req1_tag;
  logic        resp_valid, resp_ready, resp_src, resp_nv;
  logic [4:0]  resp_tag;
  logic [31:0] resp_data;

  int nchk = 0;
  int nfail = 0;

  fcmp_sched #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x1(req0_x1), .req0_x2(req0_x2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x1(req1_x1), .req1_x2(req1_x2), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src),
    .resp_tag(resp_tag), .resp_data(resp_data), .resp_nv(resp_nv)
  );

  always #5 clk = ~clk;

  logic       mon_en = 1'b0;
  logic [5:0] rq[$];
  always @(negedge clk)
    if (mon_en && !rst && resp_valid && resp_ready) rq.push_back({resp_src, resp_tag});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Issue one op from an idle pipe with resp_ready=1 and check the response.
  task automatic do_op(input logic s, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t,
                       input logic ed, input logic en, input logic lat);
    if (!s) begin
      req0_valid = 1'b1; req0_op = op; req0_x1 = a; req0_x2 = b; req0_tag = t;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_x1 = a; req1_x2 = b; req1_tag = t;
    end
    @(negedge clk);
    chk("op_rdy", s ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    if (lat) chk("lat1_vld", resp_valid, 0);
    tick();
    @(negedge clk);
    chk("op_vld", resp_valid, 1);
    chk("op_src", resp_src, s);
    chk("op_tag", resp_tag, t);
    chk("op_data", resp_data, {31'b0, ed});
    chk("op_nv", resp_nv, en);
    tick();
  endtask

  function automatic real fp2r(input logic [31:0] f);
    real m;
    int  e;
    e = int'(f[30:23]);
    m = real'(f[22:0]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = m * (2.0 ** -149);
    else             m = (m + 8388608.0) * (2.0 ** (e - 150));
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 7))
      0: f[30:0] = {8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      1: f[30:0] = {8'hFF, 23'h0};
      2: f[30:23] = 8'h00;
      default: f[30:23] = 8'($urandom_range(0, 254));
    endcase
    return f;
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  logic [31:0] ra, rb;
  logic [1:0]  rop;
  logic        red, ren;
  int          k0, k1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; resp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_x1 = 0; req0_x2 = 0; req0_tag = 0;
    req1_valid = 0; req1_op = 0; req1_x1 = 0; req1_x2 = 0; req1_tag = 0;
    @(negedge clk);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_vld", resp_valid, 0);
    chk("rst_src", resp_src, 0);
    chk("rst_tag", resp_tag, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_nv", resp_nv, 0);
    tick();
    rst = 1'b0;

    // directed compare vectors
    do_op(0, 2'b01, 32'h3F800000, 32'h40000000, 5'd3, 1, 0, 1);
    do_op(0, 2'b10, 32'h80000000, 32'h00000000, 5'd4, 1, 0, 0);
    do_op(0, 2'b00, 32'h80000000, 32'h00000000, 5'd5, 1, 0, 0);
    do_op(0, 2'b01, 32'h80000000, 32'h00000000, 5'd6, 0, 0, 0);
    do_op(0, 2'b01, 32'h00000001, 32'h00000002, 5'd7, 1, 0, 0);
    do_op(0, 2'b01, 32'hFF800000, 32'h7F800000, 5'd8, 1, 0, 0);
    do_op(0, 2'b00, 32'h7FC00000, 32'h3F800000, 5'd9, 0, 0, 0);
    do_op(0, 2'b00, 32'h7F800001, 32'h3F800000, 5'd10, 0, 1, 0);
    do_op(0, 2'b01, 32'h7FC00000, 32'h3F800000, 5'd11, 0, 1, 0);
    do_op(1, 2'b11, 32'h3F800000, 32'h3F800000, 5'd12, 0, 0, 0);
    do_op(1, 2'b11, 32'h7F800001, 32'h3F800000, 5'd13, 0, 0, 0);
    do_op(1, 2'b01, 32'hC0000000, 32'hBF800000, 5'd14, 1, 0, 0);
    do_op(1, 2'b10, 32'h3F800000, 32'h3F800000, 5'd15, 1, 0, 0);
    do_op(1, 2'b01, 32'h3F800000, 32'h3F800000, 5'd16, 0, 0, 0);

    // round-robin with both requesters continuously valid
    do_rst();
    rq.delete(); mon_en = 1'b1; resp_ready = 1'b1; k0 = 0; k1 = 0;
    req0_op = 2'b01; req1_op = 2'b01;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_tag = 5'(10 + k0);
      req1_valid = 1'b1; req1_tag = 5'(20 + k1);
      @(negedge clk);
      chk("rr_rdy0", req0_ready, (i % 2) == 0);
      chk("rr_rdy1", req1_ready, (i % 2) == 1);
      if (i % 2 == 0) k0++; else k1++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("rr_cnt", rq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (rq.size() > i) chk("rr_ord", rq[i], {1'(i % 2), 5'((i % 2) ? 20 + i / 2 : 10 + i / 2)});

    // backpressure: only two ops fit while resp_ready is low
    rq.delete(); resp_ready = 1'b0; k0 = 0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req0_tag = 5'(k0);
      @(negedge clk);
      chk("bp_rdy", req0_ready, i < 2);
      if (req0_ready) k0++;
      tick();
    end
    req0_valid = 1'b0; resp_ready = 1'b1;
    repeat (4) tick();
    chk("bp_cnt", rq.size(), 2);
    for (int i = 0; i < 2; i++)
      if (rq.size() > i) chk("bp_ord", rq[i], {1'b0, 5'(i)});

    // flush mid-stall
    mon_en = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_tag = 5'(i);
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    chk("fls_vld_pre", resp_valid, 1);
    chk("fls_rdy", req0_ready, 0);
    tick();
    flush = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("fls_vld", resp_valid, 0);
    chk("fls_rdy_after", req0_ready, 1);

    // flush while draining: the op leaving S2 that cycle is still delivered
    do_rst();
    rq.delete(); mon_en = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_tag = 5'(i);
      tick();
    end
    req0_tag = 5'd2; flush = 1'b1;
    @(negedge clk);
    chk("fld_rdy", req0_ready, 0);
    tick();
    flush = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("fld_vld", resp_valid, 0);
    repeat (3) tick();
    chk("fld_cnt", rq.size(), 1);
    if (rq.size() > 0) chk("fld_tag", rq[0], 6'd0);
    mon_en = 1'b0;

    // swept compares against a real-valued model
    for (int i = 0; i < 48; i++) begin
      ra = rnd_fp();
      case (i % 4)
        0: rb = ra;
        1: rb = {~ra[31], ra[30:0]};
        default: rb = rnd_fp();
      endcase
      rop = 2'($urandom_range(0, 2));
      if (is_nan(ra) || is_nan(rb)) begin
        red = 1'b0;
        ren = (rop != 2'b00) || (is_nan(ra) && !ra[22]) || (is_nan(rb) && !rb[22]);
      end else begin
        ren = 1'b0;
        case (rop)
          2'b00:   red = fp2r(ra) == fp2r(rb);
          2'b01:   red = fp2r(ra) <  fp2r(rb);
          default: red = fp2r(ra) <= fp2r(rb);
        endcase
      end
      do_op(1'(i % 2), rop, ra, rb, 5'(i), red, ren, 0);
    end

    // async reset mid-stream
    resp_ready = 1'b1; req0_op = 2'b01;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1'b1; req0_tag = 5'(i + 1);
      tick();
    end
    @(negedge clk);
    chk("ar_vld_pre", resp_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_vld", resp_valid, 0);
    chk("ar_rdy", req0_ready, 0);
    chk("ar_tag", resp_tag, 0);
    tick();
    rst = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    chk("ar_vld_post", resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
